hub75_scan_sequencer: RTL and testbench

- Drives the HUB75 panel from the dual-port frame RAM read side.
- Generates RAM read addresses and selects the bit-plane from each returned pixel word.
- Generates shift clock, latch, OE and row address, with binary-code-modulation (BCM) display timing.
- Owns the display-buffer select, and flips it at frame boundaries under a swap handshake with the SPI write side.

---
 rtl/hub75_scan_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_hub75_scan_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_sequencer.sv
// HUB75 scan sequencer: frame-RAM reads, bit-plane select, BCM shift/latch/OE timing, buffer swap.
// Optional HUB75_SCAN_BRIGHTNESS_EN adds a per-frame brightness input that trims OE-low time.
module hub75_scan_sequencer #(
    parameter int unsigned COL_BITS = 6,
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned PLANES   = 8,
    parameter int unsigned BASE_OE  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         read_buf,
    output logic [ROW_BITS+COL_BITS-1:0] read_addr,
    input  logic [31:0]                  read_data_top,
    input  logic [31:0]                  read_data_bottom,
`ifdef HUB75_SCAN_BRIGHTNESS_EN
    input  logic [7:0]                   brightness,
`endif
    output logic [1:0]                   hub75_red,
    output logic [1:0]                   hub75_green,
    output logic [1:0]                   hub75_blue,
    output logic [ROW_BITS-1:0]          hub75_addr,
    output logic                         hub75_clk,
    output logic                         hub75_latch,
    output logic                         hub75_oe,
    output logic                         frame_start
);

    localparam int unsigned PW  = (PLANES > 1) ? $clog2(PLANES) : 1;
    // Shift counter: bit 0 is the column phase, the top bit marks the tail cycle.
    localparam int unsigned SW  = COL_BITS + 2;
    localparam int unsigned LSB = 8 - PLANES;
    localparam logic [PW-1:0] LAST_PLANE = PW'(PLANES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StLatch, StDisplay} state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         sc_q, sc_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [PW-1:0]         plane_q, plane_d;
    logic [31:0]           disp_q, disp_d;
    logic [1:0]            red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [ROW_BITS-1:0]   addr_q, addr_d;
    logic                  clk_q, clk_d;
    logic                  buf_q, buf_d;
    logic                  ack_q, ack_d;
    logic                  fs_q;
    logic                  frame_go;
    logic                  tail, disp_last, oe_on;
    logic [31:0]           disp_len;
    logic [4:0]            bit_r, bit_g, bit_b;

    assign tail      = sc_q[SW-1];
    assign disp_len  = 32'(BASE_OE) << plane_q;
    assign disp_last = (disp_q == disp_len - 32'd1);
    assign bit_r     = 5'(24 + LSB) + 5'(plane_q);
    assign bit_g     = 5'(16 + LSB) + 5'(plane_q);
    assign bit_b     = 5'(8 + LSB) + 5'(plane_q);

`ifdef HUB75_SCAN_BRIGHTNESS_EN
    logic [7:0] bright_q;

    assign oe_on = (disp_q < ((disp_len * (32'(bright_q) + 32'd1)) >> 8));

    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= 8'd0;
        end else if (frame_go) begin
            bright_q <= brightness;
        end
    end
`else
    assign oe_on = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        sc_d     = sc_q;
        row_d    = row_q;
        plane_d  = plane_q;
        disp_d   = disp_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        addr_d   = addr_q;
        clk_d    = 1'b0;
        buf_d    = buf_q;
        ack_d    = 1'b0;
        frame_go = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    frame_go = 1'b1;
                    row_d    = '0;
                    plane_d  = '0;
                end
            end
            StShift: begin
                if (tail) begin
                    state_d = StLatch;
                    addr_d  = row_q;
                end else begin
                    sc_d = sc_q + SW'(1);
                    // Phase 1: RAM word for this column has arrived; clock it out next cycle.
                    if (sc_q[0]) begin
                        clk_d   = 1'b1;
                        red_d   = {read_data_top[bit_r], read_data_bottom[bit_r]};
                        green_d = {read_data_top[bit_g], read_data_bottom[bit_g]};
                        blue_d  = {read_data_top[bit_b], read_data_bottom[bit_b]};
                    end
                end
            end
            StLatch: begin
                state_d = StDisplay;
                disp_d  = '0;
            end
            StDisplay: begin
                if (!disp_last) begin
                    disp_d = disp_q + 32'd1;
                end else begin
                    state_d = StShift;
                    sc_d    = '0;
                    if (plane_q != LAST_PLANE) begin
                        plane_d = plane_q + PW'(1);
                    end else begin
                        plane_d = '0;
                        row_d   = row_q + ROW_BITS'(1);
                        if (row_q == '1) begin
                            if (swap_req) begin
                                buf_d = ~buf_q;
                                ack_d = 1'b1;
                            end
                            if (enable) begin
                                frame_go = 1'b1;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (frame_go) begin
            state_d = StShift;
            sc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sc_q    <= '0;
            row_q   <= '0;
            plane_q <= '0;
            disp_q  <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            addr_q  <= '0;
            clk_q   <= 1'b0;
            buf_q   <= 1'b0;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            disp_q  <= disp_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            addr_q  <= addr_d;
            clk_q   <= clk_d;
            buf_q   <= buf_d;
            ack_q   <= ack_d;
            fs_q    <= frame_go;
        end
    end

    assign read_addr   = {row_q, sc_q[COL_BITS:1]};
    assign read_buf    = buf_q;
    assign swap_ack    = ack_q;
    assign frame_start = fs_q;
    assign hub75_red   = red_q;
    assign hub75_green = green_q;
    assign hub75_blue  = blue_q;
    assign hub75_addr  = addr_q;
    assign hub75_clk   = clk_q;
    assign hub75_latch = (state_q == StLatch);
    assign hub75_oe    = !((state_q == StDisplay) && oe_on);

endmodule

// File: tb/tb_hub75_scan_sequencer.sv
// Self-checking bench for hub75_scan_sequencer: per-cycle reference timing derived from frame
// arithmetic, random RAM contents, swap handshake, enable drop and reset behaviour.
module tb_hub75_scan_sequencer;

    localparam int CB     = 2;
    localparam int RB     = 2;
    localparam int NP     = 4;
    localparam int BO     = 2;
    localparam int N      = 1 << CB;
    localparam int ROWS   = 1 << RB;
    localparam int AW     = RB + CB;
    localparam int R      = NP * (2 * N + 2) + BO * ((1 << NP) - 1);
    localparam int F      = ROWS * R;

    logic          clk = 1'b0;
    logic          reset, enable, swap_req;
    logic          swap_ack, read_buf;
    logic [AW-1:0] read_addr;
    logic [31:0]   rd_top, rd_bot;
    logic [1:0]    hub75_red, hub75_green, hub75_blue;
    logic [RB-1:0] hub75_addr;
    logic          hub75_clk, hub75_latch, hub75_oe, frame_start;
`ifdef HUB75_SCAN_BRIGHTNESS_EN
    logic [7:0]    brightness;
`endif

    logic [31:0]   mem_top [2 * ROWS * N];
    logic [31:0]   mem_bot [2 * ROWS * N];
    logic          exp_buf;
    int            total = 0;
    int            bad   = 0;

    hub75_scan_sequencer #(
        .COL_BITS(CB), .ROW_BITS(RB), .PLANES(NP), .BASE_OE(BO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .swap_req(swap_req),
        .swap_ack(swap_ack), .read_buf(read_buf), .read_addr(read_addr),
        .read_data_top(rd_top), .read_data_bottom(rd_bot),
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .hub75_red(hub75_red), .hub75_green(hub75_green), .hub75_blue(hub75_blue),
        .hub75_addr(hub75_addr), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch),
        .hub75_oe(hub75_oe), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Dual-port frame RAM read side, one-cycle latency.
    always @(posedge clk) begin
        rd_top <= mem_top[{read_buf, read_addr}];
        rd_bot <= mem_bot[{read_buf, read_addr}];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int oe_low_len(input int p);
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        return ((BO << p) * (int'(brightness) + 1)) >> 8;
`else
        return BO << p;
`endif
    endfunction

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * F + 20; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int clk_hi, oe_lo;
        reset = 1'b1; enable = 1'b0; swap_req = 1'b0;
        repeat (3) @(negedge clk);
        exp_buf = 1'b0;
        total++;
        if ({swap_ack, read_buf, hub75_clk, hub75_latch, hub75_oe, frame_start} !== 6'b000010) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {swap_ack, read_buf, hub75_clk, hub75_latch, hub75_oe, frame_start}, 6'b000010);
        end
        total++;
        if (read_addr !== '0) begin
            bad++; $display("FAIL reset_read_addr got=%h exp=0", read_addr);
        end
        total++;
        if ({hub75_red, hub75_green, hub75_blue} !== 6'b0) begin
            bad++; $display("FAIL reset_rgb got=%b exp=0", {hub75_red, hub75_green, hub75_blue});
        end
        total++;
        if (hub75_addr !== '0) begin
            bad++; $display("FAIL reset_hub75_addr got=%h exp=0", hub75_addr);
        end
        reset = 1'b0;
        clk_hi = 0; oe_lo = 0;
        repeat (100) begin
            @(negedge clk);
            if (hub75_clk !== 1'b0) clk_hi++;
            if (hub75_oe !== 1'b1 || frame_start !== 1'b0) oe_lo++;
        end
        total++;
        if (clk_hi != 0 || oe_lo != 0) begin
            bad++; $display("FAIL idle_quiet got clk_hi=%0d active=%0d exp=0,0", clk_hi, oe_lo);
        end
    endtask

    task automatic test_scan(input int nframes);
        bit ok;
        int tt, row, p, s, d, idx, thr, bt;
        logic [AW-1:0] ea;
        logic [1:0] er, eg, eb;
        logic eclk, eoe;
        for (int i = 0; i < 2 * ROWS * N; i++) begin
            mem_top[i] = $urandom;
            mem_bot[i] = $urandom;
        end
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        brightness = 8'($urandom_range(0, 255));
`endif
        enable = 1'b1;
        wait_frame_start(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL scan_start got=no frame_start exp=frame_start");
            return;
        end
        for (int t = 0; t < nframes * F; t++) begin
            if (t > 0) @(negedge clk);
            tt = t % F; row = tt / R; s = tt % R; p = 0;
            while (s >= 2 * N + 2 + (BO << p)) begin
                s -= 2 * N + 2 + (BO << p);
                p++;
            end
            thr = oe_low_len(p);
            total++;
            if (frame_start !== (tt == 0)) begin
                bad++; $display("FAIL scan_frame_start t=%0d got=%b exp=%b", tt, frame_start, tt == 0);
            end
            total++;
            if (swap_ack !== 1'b0 || read_buf !== exp_buf) begin
                bad++; $display("FAIL scan_buf t=%0d got=%b%b exp=0%b", tt, swap_ack, read_buf, exp_buf);
            end
            if (s <= 2 * N) begin
                eclk = (s >= 2 && s % 2 == 0);
                total++;
                if (hub75_clk !== eclk || hub75_oe !== 1'b1 || hub75_latch !== 1'b0) begin
                    bad++;
                    $display("FAIL scan_shift t=%0d got clk/oe/lat=%b%b%b exp=%b10",
                             tt, hub75_clk, hub75_oe, hub75_latch, eclk);
                end
                if (s < 2 * N && s % 2 == 0) begin
                    ea = AW'(row * N + s / 2);
                    total++;
                    if (read_addr !== ea) begin
                        bad++; $display("FAIL scan_read_addr t=%0d got=%h exp=%h", tt, read_addr, ea);
                    end
                end
                if (eclk) begin
                    idx = int'(exp_buf) * ROWS * N + row * N + s / 2 - 1;
                    bt  = 32 - NP + p;
                    er  = {mem_top[idx][bt], mem_bot[idx][bt]};
                    eg  = {mem_top[idx][bt - 8], mem_bot[idx][bt - 8]};
                    eb  = {mem_top[idx][bt - 16], mem_bot[idx][bt - 16]};
                    total++;
                    if ({hub75_red, hub75_green, hub75_blue} !== {er, eg, eb}) begin
                        bad++;
                        $display("FAIL scan_rgb t=%0d got=%b exp=%b", tt,
                                 {hub75_red, hub75_green, hub75_blue}, {er, eg, eb});
                    end
                end
            end else if (s == 2 * N + 1) begin
                total++;
                if (hub75_latch !== 1'b1 || hub75_oe !== 1'b1 || hub75_clk !== 1'b0 ||
                    hub75_addr !== RB'(row)) begin
                    bad++;
                    $display("FAIL scan_latch t=%0d got lat/oe/clk=%b%b%b addr=%0d exp=110 addr=%0d",
                             tt, hub75_latch, hub75_oe, hub75_clk, hub75_addr, row);
                end
            end else begin
                d   = s - 2 * N - 2;
                eoe = !(d < thr);
                total++;
                if (hub75_oe !== eoe || hub75_latch !== 1'b0 || hub75_clk !== 1'b0 ||
                    hub75_addr !== RB'(row)) begin
                    bad++;
                    $display("FAIL scan_display t=%0d got oe/lat/clk=%b%b%b addr=%0d exp=%b00 addr=%0d",
                             tt, hub75_oe, hub75_latch, hub75_clk, hub75_addr, eoe, row);
                end
            end
        end
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        brightness = 8'd255;
`endif
    endtask

    task automatic test_swap();
        int  rise [5] = '{100, 5, -1, F - 1, -1};
        bit  drop [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit  ok, pend;
        int  f, tt;
        swap_req = 1'b0; enable = 1'b1;
        wait_frame_start(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL swap_start got=no frame_start exp=frame_start");
            return;
        end
        pend = 1'b0;
        for (int t = 0; t <= 5 * F; t++) begin
            if (t > 0) @(negedge clk);
            f = t / F; tt = t % F;
            if (tt == 0 && pend) exp_buf = ~exp_buf;
            total++;
            if (swap_ack !== (tt == 0 && pend)) begin
                bad++; $display("FAIL swap_ack f=%0d t=%0d got=%b exp=%b", f, tt, swap_ack, tt == 0 && pend);
            end
            total++;
            if (read_buf !== exp_buf) begin
                bad++; $display("FAIL swap_read_buf f=%0d t=%0d got=%b exp=%b", f, tt, read_buf, exp_buf);
            end
            total++;
            if (frame_start !== (tt == 0)) begin
                bad++; $display("FAIL swap_frame_start f=%0d t=%0d got=%b", f, tt, frame_start);
            end
            if (f < 5) begin
                if (tt == 0 && drop[f]) swap_req = 1'b0;
                if (tt == rise[f]) swap_req = 1'b1;
                if (tt == F - 1) pend = swap_req;
            end
        end
        swap_req = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit ok;
        int oe_lo, exp_lo, stray;
        exp_lo = 0;
        for (int p = 0; p < NP; p++) exp_lo += ROWS * oe_low_len(p);
        enable = 1'b1;
        wait_frame_start(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL drop_start got=no frame_start exp=frame_start");
            return;
        end
        oe_lo = 0; stray = 0;
        for (int tt = 0; tt < F; tt++) begin
            if (tt > 0) @(negedge clk);
            if (hub75_oe === 1'b0) oe_lo++;
            if (tt > 0 && frame_start !== 1'b0) stray++;
            if (tt == 10) enable = 1'b0;
        end
        total++;
        if (oe_lo != exp_lo || stray != 0) begin
            bad++; $display("FAIL drop_completes got oe_low=%0d stray_fs=%0d exp=%0d,0", oe_lo, stray, exp_lo);
        end
        stray = 0;
        repeat (60) begin
            @(negedge clk);
            if (frame_start !== 1'b0 || hub75_oe !== 1'b1 || hub75_clk !== 1'b0 ||
                hub75_latch !== 1'b0 || swap_ack !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++; $display("FAIL drop_idle got active_cycles=%0d exp=0", stray);
        end
    endtask

    task automatic test_data_mapping();
        bit ok;
        for (int i = 0; i < 2 * ROWS * N; i++) begin
            mem_top[i] = 32'h8000_0000;
            mem_bot[i] = 32'h0000_8000;
        end
        enable = 1'b1;
        wait_frame_start(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL map_start got=no frame_start exp=frame_start");
            return;
        end
        // Row 0: plane 0 first shift clock at t=2, top plane first shift clock at t=46.
        for (int tt = 0; tt <= 46; tt++) begin
            if (tt > 0) @(negedge clk);
            if (tt == 2) begin
                total++;
                if ({hub75_clk, hub75_red, hub75_green, hub75_blue} !== 7'b1_00_00_00) begin
                    bad++;
                    $display("FAIL map_plane0 got=%b exp=1000000",
                             {hub75_clk, hub75_red, hub75_green, hub75_blue});
                end
            end
            if (tt == 46) begin
                total++;
                if ({hub75_clk, hub75_red, hub75_green, hub75_blue} !== 7'b1_10_00_01) begin
                    bad++;
                    $display("FAIL map_top_plane got=%b exp=1100001",
                             {hub75_clk, hub75_red, hub75_green, hub75_blue});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        enable = 1'b1;
        wait_frame_start(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rmid_start got=no frame_start exp=frame_start");
            return;
        end
        repeat (59) @(negedge clk);
        total++;
        if (hub75_oe !== 1'b0) begin
            bad++; $display("FAIL rmid_display got oe=%b exp=0", hub75_oe);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_buf = 1'b0;
        total++;
        if ({hub75_oe, hub75_clk, hub75_latch, frame_start, swap_ack, read_buf} !== 6'b100000) begin
            bad++;
            $display("FAIL rmid_ctrl got=%b exp=100000",
                     {hub75_oe, hub75_clk, hub75_latch, frame_start, swap_ack, read_buf});
        end
        total++;
        if ({read_addr, hub75_addr, hub75_red, hub75_green, hub75_blue} !== '0) begin
            bad++;
            $display("FAIL rmid_data got addr=%h row=%h rgb=%b exp=0", read_addr, hub75_addr,
                     {hub75_red, hub75_green, hub75_blue});
        end
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (hub75_oe !== 1'b1 || frame_start !== 1'b0) begin
            bad++; $display("FAIL rmid_idle got oe=%b fs=%b exp=1,0", hub75_oe, frame_start);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; swap_req = 1'b0; exp_buf = 1'b0;
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        brightness = 8'd255;
`endif
        test_reset();
        test_scan(2);
        test_swap();
        test_enable_drop();
        test_data_mapping();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
